alu_add_seq: RTL and testbench

- Multi-cycle sequencer for the calculator's BCD add/subtract datapath. Operates on calc_pkg::num_t operands: sign, NumDigits BCD significand digits, exponent and error.
- Value convention: value = (sign ? -1 : 1) × significand × 10^exponent, with exponent in 0..NumDigits-1.
- Accepts one operation over a valid/ready handshake. Processing order: align exponents, digit-serial add/subtract, then normalize. Returns the result over a second valid/ready handshake.
- Sits between the keypad/operation control FSM and the display register. Intended to be bit-exact against the golden add model.

---
 rtl/calc_pkg.sv | 12 +
 rtl/alu_add_seq.sv | 211 +++++++++++++++++++++
 tb/tb_alu_add_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator number format: sign, BCD significand, exponent and error flag.
package calc_pkg;
    localparam int NumDigits = 8;
    localparam int ExpW      = $clog2(NumDigits);

    typedef struct packed {
        logic                   err;
        logic                   sign;
        logic [NumDigits*4-1:0] sig;
        logic [ExpW-1:0]        expo;
    } num_t;
endpackage

// File: rtl/alu_add_seq.sv
// Multi-cycle BCD add/subtract sequencer: exponent align, digit-serial add/sub, normalize.
//   state    | meaning
//   S_IDLE   | ready for a new operation
//   S_ALIGN  | shift smaller-exponent significand right one digit per cycle
//   S_ADDSUB | one BCD digit per cycle, LSD first, registered carry/borrow
//   S_NORM   | carry shift / left normalize, one step per cycle
//   S_DONE   | result held until the consumer accepts it
module alu_add_seq #(
    parameter int NumDigits = calc_pkg::NumDigits,
    parameter int MaxExp    = NumDigits - 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic                               op_sub_i,
    input  logic [$bits(calc_pkg::num_t)-1:0]  left_i,
    input  logic [$bits(calc_pkg::num_t)-1:0]  right_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [$bits(calc_pkg::num_t)-1:0]  result_o,
    output logic                               busy_o
);
    localparam int SigW = NumDigits * 4;
    localparam int ExpW = $bits(calc_pkg::num_t) - SigW - 2;
    localparam int IdxW = $clog2(NumDigits);
    localparam int CntW = $clog2(NumDigits + 1);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [SigW-1:0]   a_sig_q, a_sig_d, b_sig_q, b_sig_d, r_sig_q, r_sig_d;
    logic              a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic              shift_a_q, shift_a_d;
    logic [ExpW-1:0]   exp_q, exp_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;
    calc_pkg::num_t    result_q, result_d;

    calc_pkg::num_t    left_n, right_n;
    logic              exp_l_lt_r;
    logic [ExpW-1:0]   exp_diff;
    logic [CntW-1:0]   shift_cnt;
    logic              same_sign, mag_a_ge, res_sign;
    logic [SigW-1:0]   x_sig, y_sig;
    logic [IdxW-1:0]   idx;
    logic [3:0]        xd, yd, dig;
    logic [4:0]        sum;
    logic              cout;

    assign left_n  = left_i;
    assign right_n = right_i;

    assign exp_l_lt_r = left_n.expo < right_n.expo;
    assign exp_diff   = exp_l_lt_r ? (right_n.expo - left_n.expo) : (left_n.expo - right_n.expo);
    assign shift_cnt  = (CntW'(exp_diff) >= CntW'(NumDigits)) ? CntW'(NumDigits) : CntW'(exp_diff);

    // Exponents are equal after alignment, so packed BCD compares like binary.
    assign same_sign = a_sign_q == b_sign_q;
    assign mag_a_ge  = a_sig_q >= b_sig_q;
    assign x_sig     = (same_sign || mag_a_ge) ? a_sig_q : b_sig_q;
    assign y_sig     = (same_sign || mag_a_ge) ? b_sig_q : a_sig_q;
    assign res_sign  = same_sign ? a_sign_q :
                       (a_sig_q == b_sig_q) ? 1'b0 :
                       (mag_a_ge ? a_sign_q : b_sign_q);

    assign idx = IdxW'(NumDigits - 1) - IdxW'(cnt_q);
    assign xd  = x_sig[{idx, 2'b00} +: 4];
    assign yd  = y_sig[{idx, 2'b00} +: 4];

    always_comb begin
        sum  = '0;
        dig  = '0;
        cout = 1'b0;
        if (same_sign) begin
            sum  = {1'b0, xd} + {1'b0, yd} + {4'b0, carry_q};
            cout = sum > 5'd9;
            dig  = cout ? (sum[3:0] + 4'd6) : sum[3:0];
        end else begin
            sum  = {1'b0, xd} - {1'b0, yd} - {4'b0, carry_q};
            cout = sum[4];
            dig  = cout ? (sum[3:0] + 4'd10) : sum[3:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        a_sig_d   = a_sig_q;
        b_sig_d   = b_sig_q;
        r_sig_d   = r_sig_q;
        a_sign_d  = a_sign_q;
        b_sign_d  = b_sign_q;
        shift_a_d = shift_a_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        sign_d    = sign_q;
        err_d     = err_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_sig_d   = left_n.sig;
                    a_sign_d  = left_n.sign;
                    b_sig_d   = right_n.sig;
                    b_sign_d  = right_n.sign ^ op_sub_i;
                    shift_a_d = exp_l_lt_r;
                    exp_d     = exp_l_lt_r ? right_n.expo : left_n.expo;
                    err_d     = 1'b0;
                    carry_d   = 1'b0;
                    if (left_n.err || right_n.err) begin
                        result_d     = '0;
                        result_d.err = 1'b1;
                        state_d      = S_DONE;
                    end else if (shift_cnt == '0) begin
                        cnt_d   = CntW'(NumDigits - 1);
                        state_d = S_ADDSUB;
                    end else begin
                        cnt_d   = shift_cnt;
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (shift_a_q) a_sig_d = a_sig_q >> 4;
                else           b_sig_d = b_sig_q >> 4;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    cnt_d   = CntW'(NumDigits - 1);
                    carry_d = 1'b0;
                    state_d = S_ADDSUB;
                end
            end
            S_ADDSUB: begin
                r_sig_d = {dig, r_sig_q[SigW-1:4]};
                carry_d = cout;
                sign_d  = res_sign;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_NORM;
            end
            S_NORM: begin
                if (err_q) begin
                    result_d     = '0;
                    result_d.err = 1'b1;
                    state_d      = S_DONE;
                end else if (carry_q) begin
                    carry_d = 1'b0;
                    if (exp_q == ExpW'(MaxExp)) begin
                        err_d = 1'b1;
                    end else begin
                        r_sig_d = {4'd1, r_sig_q[SigW-1:4]};
                        exp_d   = exp_q + 1'b1;
                    end
                end else if (exp_q != '0 && r_sig_q[SigW-1 -: 4] == 4'd0) begin
                    r_sig_d = {r_sig_q[SigW-5:0], 4'd0};
                    exp_d   = exp_q - 1'b1;
                end else begin
                    result_d.err  = 1'b0;
                    result_d.sign = (r_sig_q == '0) ? 1'b0 : sign_q;
                    result_d.sig  = r_sig_q;
                    result_d.expo = exp_q;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            a_sig_q   <= '0;
            b_sig_q   <= '0;
            r_sig_q   <= '0;
            a_sign_q  <= 1'b0;
            b_sign_q  <= 1'b0;
            shift_a_q <= 1'b0;
            exp_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_sig_q   <= a_sig_d;
            b_sig_q   <= b_sig_d;
            r_sig_q   <= r_sig_d;
            a_sign_q  <= a_sign_d;
            b_sign_q  <= b_sign_d;
            shift_a_q <= shift_a_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            sign_q    <= sign_d;
            err_q     <= err_d;
            result_q  <= result_d;
        end
    end

    assign in_ready_o  = state_q == S_IDLE;
    assign out_valid_o = state_q == S_DONE;
    assign busy_o      = state_q != S_IDLE;
    assign result_o    = result_q;
endmodule

// File: tb/tb_alu_add_seq.sv
// Directed bench for alu_add_seq with a result/latency scoreboard.
module tb_alu_add_seq;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           op_sub = 1'b0;
    calc_pkg::num_t left_v = '0;
    calc_pkg::num_t right_v = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    calc_pkg::num_t result;
    logic           busy;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        calc_pkg::num_t res;
        int             lat;
        string          tag;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    alu_add_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_sub_i    (op_sub),
        .left_i      (left_v),
        .right_i     (right_v),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .busy_o      (busy)
    );

    function automatic calc_pkg::num_t mk(input logic s, input logic [31:0] d, input int e, input logic er);
        calc_pkg::num_t n;
        n.err  = er;
        n.sign = s;
        n.sig  = d;
        n.expo = 3'(e);
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input calc_pkg::num_t l, input calc_pkg::num_t r,
                         input logic sub, input calc_pkg::num_t exp_res, input int exp_lat);
        sb_t e;
        int  lat;
        e.res = exp_res;
        e.lat = exp_lat;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        left_v   = l;
        right_v  = r;
        op_sub   = sub;
        in_valid = 1'b1;
        check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        e = sb.pop_front();
        check({e.tag, "/result"}, 64'(result), 64'(e.res));
        check({e.tag, "/latency"}, 64'(lat), 64'(e.lat));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "/ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        calc_pkg::num_t err_res;
        calc_pkg::num_t held;
        sb_t            e;
        int             lat;

        err_res = mk(0, 32'h0, 0, 1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/result",    64'(result),    64'd0);
        check("reset/busy",      64'(busy),      64'd0);
        check("reset/in_ready",  64'(in_ready),  64'd1);

        do_op("add_basic",  mk(0, 32'h00000025, 0, 0), mk(0, 32'h00000017, 0, 0), 0,
              mk(0, 32'h00000042, 0, 0), 9);
        do_op("add_carry",  mk(0, 32'h99999999, 0, 0), mk(0, 32'h00000001, 0, 0), 0,
              mk(0, 32'h10000000, 1, 0), 10);
        do_op("add_ovf",    mk(0, 32'h99999999, 7, 0), mk(0, 32'h99999999, 7, 0), 0,
              err_res, 10);
        do_op("align_sub",  mk(0, 32'h10000000, 1, 0), mk(1, 32'h00000050, 0, 0), 0,
              mk(0, 32'h99999950, 0, 0), 11);
        do_op("sub_equal",  mk(0, 32'h12345678, 2, 0), mk(0, 32'h12345678, 2, 0), 1,
              mk(0, 32'h00000000, 0, 0), 11);
        do_op("sub_neg",    mk(0, 32'h00000003, 0, 0), mk(0, 32'h00000005, 0, 0), 1,
              mk(1, 32'h00000002, 0, 0), 9);
        do_op("align_far",  mk(0, 32'h12345678, 0, 0), mk(0, 32'h00000001, 7, 0), 0,
              mk(0, 32'h20000000, 0, 0), 23);

        // Error operand with the consumer stalling and extra requests arriving.
        e.res = err_res;
        e.lat = 0;
        e.tag = "err_in";
        sb.push_back(e);
        @(negedge clk);
        left_v   = mk(0, 32'h00000011, 0, 1);
        right_v  = mk(0, 32'h00000022, 0, 0);
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        e = sb.pop_front();
        check("err_in/result",  64'(result), 64'(e.res));
        check("err_in/latency", 64'(lat),    64'(e.lat));
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2) == 0;
            left_v   = mk(0, 32'h00000001, 0, 0);
            right_v  = mk(0, 32'h00000001, 0, 0);
            check("hold/result",    64'(result),    64'(err_res));
            check("hold/in_ready",  64'(in_ready),  64'd0);
            check("hold/out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        check("hold/stable", 64'(result), 64'(held));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("hold/valid_drop", 64'(out_valid), 64'd0);
        check("hold/ready_back", 64'(in_ready),  64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("hold/no_overlap", 64'(busy), 64'd0);

        // Reset in the middle of an add.
        @(negedge clk);
        left_v   = mk(0, 32'h00000025, 0, 0);
        right_v  = mk(0, 32'h00000017, 0, 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst/busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst/out_valid", 64'(out_valid), 64'd0);
        check("midrst/busy",      64'(busy),      64'd0);
        check("midrst/in_ready",  64'(in_ready),  64'd1);
        check("midrst/result",    64'(result),    64'd0);

        do_op("after_rst", mk(0, 32'h00000001, 0, 0), mk(0, 32'h00000001, 0, 0), 0,
              mk(0, 32'h00000002, 0, 0), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
